// File: rtl/fir_channel_scheduler.sv
// -----------------------------------------------------------------------------
// fir_channel_scheduler
//
// Purpose: drives the 13-band FIR equalizer datapath over its simple bus. It
// takes left/right codec samples in round-robin order, writes one sample at a
// time into the FIR (which starts a convolution), waits a short guard time,
// polls the FIR status word until the done bit is set (or a poll budget runs
// out) and presents the 16-bit result with its channel tag. Tap-count
// configuration requests are queued and written to the FIR between
// convolutions, ahead of any waiting sample.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET   clock, asynchronous active-high reset
//   cfg_load, cfg_numTaps      request to write a new tap count (pulse + value)
//   inL_*/inR_*                left/right sample inputs (valid/ready/data)
//   out_*                      result output (valid/ready/chan/data/err)
//   err_sticky                 set on poll timeout or a zero tap count
//   busy                       scheduler is not idle
//   fir_wr/fir_wrAddr/fir_wrData, fir_rd/fir_rdData   FIR simple-bus master
//   dbg_state                  current FSM state encoding
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. A producer keeps valid and data stable until that edge; ready
// may change combinationally and never depends on a transfer in flight. On
// the output side out_valid and its payload stay constant until out_ready.
// -----------------------------------------------------------------------------
module fir_channel_scheduler #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int A_NUM_TAPS = 0,
  parameter int A_IN_L     = 2,
  parameter int A_IN_R     = 3,
  parameter int POLL_GUARD = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic              cfg_load,
  input  logic [15:0]       cfg_numTaps,
  input  logic              inL_valid,
  input  logic [15:0]       inL_data,
  output logic              inL_ready,
  input  logic              inR_valid,
  input  logic [15:0]       inR_data,
  output logic              inR_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_chan,
  output logic [15:0]       out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic              busy,
  output logic              fir_wr,
  output logic [ADDR_W-1:0] fir_wrAddr,
  output logic [DATA_W-1:0] fir_wrData,
  output logic              fir_rd,
  input  logic [DATA_W-1:0] fir_rdData,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_ISSUE = 3'd2,
    S_GUARD = 3'd3,
    S_POLL  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t              state_q;
  logic                rr_q;           // channel preferred when both are valid (0=left)
  logic                cfg_pending_q;
  logic                chan_q;
  logic [15:0]         gcnt_q;
  logic [15:0]         tcnt_q;
  logic                out_valid_q;
  logic                out_chan_q;
  logic [15:0]         out_data_q;
  logic                out_err_q;
  logic                err_sticky_q;
  logic                fir_wr_q;
  logic [ADDR_W-1:0]   fir_wrAddr_q;
  logic [DATA_W-1:0]   fir_wrData_q;
  logic                fir_rd_q;

  logic grant_r;
  logic can_accept;
  logic take;

  // Right wins when it is the only valid channel, or when both are valid and
  // the round-robin pointer says it is right's turn.
  always_comb begin
    grant_r    = inR_valid && (!inL_valid || rr_q);
    // Reset is included so the ready outputs read 0 the moment reset rises.
    can_accept = (state_q == S_IDLE) && !cfg_pending_q && !out_valid_q && !S_AXI_ARESET;
    inL_ready  = can_accept && inL_valid && !grant_r;
    inR_ready  = can_accept && grant_r;
    take       = (inL_valid && inL_ready) || (inR_valid && inR_ready);
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q       <= S_IDLE;
      rr_q          <= 1'b0;
      cfg_pending_q <= 1'b0;
      chan_q        <= 1'b0;
      gcnt_q        <= 16'd0;
      tcnt_q        <= 16'd0;
      out_valid_q   <= 1'b0;
      out_chan_q    <= 1'b0;
      out_data_q    <= 16'd0;
      out_err_q     <= 1'b0;
      err_sticky_q  <= 1'b0;
      fir_wr_q      <= 1'b0;
      fir_wrAddr_q  <= '0;
      fir_wrData_q  <= '0;
      fir_rd_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_pending_q) begin
            // A zero tap count is never written to the FIR; it only flags an error.
            cfg_pending_q <= 1'b0;
            fir_wr_q      <= (cfg_numTaps != 16'd0);
            fir_wrAddr_q  <= ADDR_W'(A_NUM_TAPS);
            fir_wrData_q  <= DATA_W'(cfg_numTaps);
            if (cfg_numTaps == 16'd0) err_sticky_q <= 1'b1;
            state_q       <= S_CFG;
          end else if (take) begin
            chan_q       <= grant_r;
            fir_wr_q     <= 1'b1;
            fir_wrAddr_q <= grant_r ? ADDR_W'(A_IN_R) : ADDR_W'(A_IN_L);
            fir_wrData_q <= grant_r ? DATA_W'(inR_data) : DATA_W'(inL_data);
            state_q      <= S_ISSUE;
          end
        end
        S_CFG: begin
          fir_wr_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        S_ISSUE: begin
          fir_wr_q <= 1'b0;
          gcnt_q   <= 16'd0;
          state_q  <= S_GUARD;
        end
        S_GUARD: begin
          if (gcnt_q == 16'(POLL_GUARD - 1)) begin
            fir_rd_q <= 1'b1;
            tcnt_q   <= 16'd0;
            state_q  <= S_POLL;
          end else begin
            gcnt_q <= gcnt_q + 16'd1;
          end
        end
        S_POLL: begin
          // fir_rd is high for every cycle spent here; the status word is
          // sampled in the same cycle as the strobe.
          if (fir_rdData[31]) begin
            fir_rd_q    <= 1'b0;
            out_valid_q <= 1'b1;
            out_chan_q  <= chan_q;
            out_data_q  <= fir_rdData[15:0];
            out_err_q   <= 1'b0;
            state_q     <= S_OUT;
          end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
            fir_rd_q     <= 1'b0;
            out_valid_q  <= 1'b1;
            out_chan_q   <= chan_q;
            out_data_q   <= 16'd0;
            out_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            state_q      <= S_OUT;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rr_q        <= ~chan_q;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          fir_wr_q <= 1'b0;
          fir_rd_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
      // Placed last so a request arriving in the same cycle that the previous
      // one is taken is not lost.
      if (cfg_load) cfg_pending_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_chan   = out_chan_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign busy       = (state_q != S_IDLE);
  assign fir_wr     = fir_wr_q;
  assign fir_wrAddr = fir_wrAddr_q;
  assign fir_wrData = fir_wrData_q;
  assign fir_rd     = fir_rd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
module tb_fir_channel_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_load = 1'b0;
  logic [15:0] cfg_numTaps = 16'd0;
  logic        inL_valid = 1'b0, inR_valid = 1'b0;
  logic [15:0] inL_data = 16'd0, inR_data = 16'd0;
  logic        inL_ready, inR_ready;
  logic        out_valid, out_chan, out_err;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        err_sticky, busy, fir_wr, fir_rd;
  logic [5:0]  fir_wrAddr;
  logic [31:0] fir_wrData, fir_rdData;
  logic [2:0]  dbg_state;

  fir_channel_scheduler dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .cfg_load    (cfg_load),
    .cfg_numTaps (cfg_numTaps),
    .inL_valid   (inL_valid),
    .inL_data    (inL_data),
    .inL_ready   (inL_ready),
    .inR_valid   (inR_valid),
    .inR_data    (inR_data),
    .inR_ready   (inR_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_chan    (out_chan),
    .out_data    (out_data),
    .out_err     (out_err),
    .err_sticky  (err_sticky),
    .busy        (busy),
    .fir_wr      (fir_wr),
    .fir_wrAddr  (fir_wrAddr),
    .fir_wrData  (fir_wrData),
    .fir_rd      (fir_rd),
    .fir_rdData  (fir_rdData),
    .dbg_state   (dbg_state)
  );

  // ---------------- FIR model + bus monitor ----------------
  // Convolution takes numTaps+2 cycles after the sample write; the result is
  // the sample arithmetically shifted right by one.
  logic [15:0] m_taps = 16'd0;
  int          m_cnt = 0;
  logic        m_never_done = 1'b0;
  logic [15:0] m_res = 16'd0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  logic [37:0] wr_q[$];
  logic [37:0] exp_q[$];

  assign fir_rdData = {(!m_never_done && m_cnt == 0), 15'd0, m_res};

  always @(negedge clk) begin
    if (m_cnt > 0) m_cnt = m_cnt - 1;
    if (fir_wr) begin
      wr_q.push_back({fir_wrAddr, fir_wrData});
      if (fir_wrAddr == 6'd0) m_taps = fir_wrData[15:0];
      else begin
        m_cnt = int'(m_taps) + 2;
        m_res = 16'($signed(fir_wrData[15:0]) >>> 1);
      end
    end
    if (fir_rd) rd_cnt = rd_cnt + 1;
    if (fir_wr && fir_rd) both_cnt = both_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, 38'(wr_q.size()), 38'(exp_q.size()));
    while (wr_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " write"}, wr_q.pop_front(), exp_q.pop_front());
    wr_q.delete();
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic ch, input logic [15:0] d, input string tag);
    bit got = 1'b0;
    if (ch) begin inR_valid = 1'b1; inR_data = d; end
    else    begin inL_valid = 1'b1; inL_data = d; end
    #1;
    for (int i = 0; i < 2000 && !got; i++) begin
      if ((ch ? inR_ready : inL_ready) === 1'b1) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    chk({tag, " accept"}, 38'(got), 38'd1);
    @(negedge clk);
    if (ch) inR_valid = 1'b0; else inL_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, " out_valid"}, 38'(seen), 38'd1);
  endtask

  task automatic pulse_cfg(input logic [15:0] taps);
    cfg_numTaps = taps;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    bit seen_rd;

    // Reset: hold a valid input to show ready stays low under reset.
    inL_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 38'(out_valid), 38'd0);
    chk("reset fir_wr", 38'(fir_wr), 38'd0);
    chk("reset fir_rd", 38'(fir_rd), 38'd0);
    chk("reset busy", 38'(busy), 38'd0);
    chk("reset err_sticky", 38'(err_sticky), 38'd0);
    chk("reset inL_ready", 38'(inL_ready), 38'd0);
    inL_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // T1: tap-count write only
    pulse_cfg(16'd4);
    repeat (5) @(negedge clk);
    expect_wr(6'd0, 32'h0000_0004);
    check_writes("T1");
    chk("T1 reads", 38'(rd_cnt), 38'd0);

    // T2: single left sample, 6-cycle conv -> 4 polls
    rd_cnt = 0;
    out_ready = 1'b1;
    send(1'b0, 16'h1000, "T2");
    wait_out(50, "T2");
    chk("T2 chan", 38'(out_chan), 38'd0);
    chk("T2 data", 38'(out_data), 38'h0800);
    chk("T2 err", 38'(out_err), 38'd0);
    chk("T2 busy", 38'(busy), 38'd1);
    @(negedge clk);
    chk("T2 consumed", 38'(out_valid), 38'd0);
    chk("T2 polls", 38'(rd_cnt), 38'd4);
    chk("T2 err_sticky", 38'(err_sticky), 38'd0);
    expect_wr(6'd2, 32'h0000_1000);
    check_writes("T2");

    // T3: both valid; left was served last so right goes first
    inL_data = 16'h0100; inR_data = 16'h0200;
    inL_valid = 1'b1; inR_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_out(60, "T3");
      chk("T3 chan", 38'(out_chan), (i % 2 == 0) ? 38'd1 : 38'd0);
      chk("T3 data", 38'(out_data), (i % 2 == 0) ? 38'h0100 : 38'h0080);
      if (i == 3) begin inL_valid = 1'b0; inR_valid = 1'b0; end
    end
    repeat (3) @(negedge clk);
    chk("T3 idle", 38'(busy), 38'd0);
    expect_wr(6'd3, 32'h0000_0200); expect_wr(6'd2, 32'h0000_0100);
    expect_wr(6'd3, 32'h0000_0200); expect_wr(6'd2, 32'h0000_0100);
    check_writes("T3");

    // T5: consumer stalls 20 cycles with both inputs waiting
    out_ready = 1'b0;
    inL_data = 16'h0300; inR_data = 16'hF000;
    inL_valid = 1'b1; inR_valid = 1'b1;
    wait_out(60, "T5");
    chk("T5 chan", 38'(out_chan), 38'd1);
    chk("T5 data", 38'(out_data), 38'hF800);
    chk("T5 err", 38'(out_err), 38'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_chan !== 1'b1 || out_data !== 16'hF800 ||
          inL_ready !== 1'b0 || inR_ready !== 1'b0) bad++;
    end
    chk("T5 hold", 38'(bad), 38'd0);
    inL_valid = 1'b0; inR_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("T5 released", 38'(out_valid), 38'd0);
    chk("T5 idle", 38'(busy), 38'd0);
    expect_wr(6'd3, 32'h0000_F000);
    check_writes("T5");

    // T4: FIR never finishes -> abort after 1024 polls
    rd_cnt = 0;
    m_never_done = 1'b1;
    send(1'b0, 16'h0123, "T4");
    wait_out(1200, "T4");
    chk("T4 chan", 38'(out_chan), 38'd0);
    chk("T4 data", 38'(out_data), 38'd0);
    chk("T4 err", 38'(out_err), 38'd1);
    chk("T4 err_sticky", 38'(err_sticky), 38'd1);
    chk("T4 polls", 38'(rd_cnt), 38'd1024);
    @(negedge clk);
    m_never_done = 1'b0;
    chk("T4 consumed", 38'(out_valid), 38'd0);
    expect_wr(6'd2, 32'h0000_0123);
    check_writes("T4");

    // Reset clears the sticky error
    #2 rst = 1'b1;
    #1 chk("T6 reset err_sticky", 38'(err_sticky), 38'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T6a: cfg_load during a conversion is written before the next sample
    send(1'b0, 16'h0600, "T6a L");
    pulse_cfg(16'd8);
    wait_out(60, "T6a L");
    chk("T6a L chan", 38'(out_chan), 38'd0);
    chk("T6a L data", 38'(out_data), 38'h0300);
    send(1'b1, 16'h0400, "T6a R");
    wait_out(80, "T6a R");
    chk("T6a R chan", 38'(out_chan), 38'd1);
    chk("T6a R data", 38'(out_data), 38'h0200);
    @(negedge clk);
    expect_wr(6'd2, 32'h0000_0600);
    expect_wr(6'd0, 32'h0000_0008);
    expect_wr(6'd3, 32'h0000_0400);
    check_writes("T6a");

    // T6b: reset while polling aborts immediately, nothing emitted after
    send(1'b0, 16'h0222, "T6b");
    seen_rd = 1'b0;
    for (int i = 0; i < 30 && !seen_rd; i++) begin
      @(negedge clk);
      if (fir_rd === 1'b1) seen_rd = 1'b1;
    end
    chk("T6b reached poll", 38'(seen_rd), 38'd1);
    #2 rst = 1'b1;
    #1;
    chk("T6b fir_rd", 38'(fir_rd), 38'd0);
    chk("T6b fir_wr", 38'(fir_wr), 38'd0);
    chk("T6b busy", 38'(busy), 38'd0);
    chk("T6b out_valid", 38'(out_valid), 38'd0);
    expect_wr(6'd2, 32'h0000_0222);
    check_writes("T6b");
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("T6b no late result", 38'(bad), 38'd0);
    chk("T6b no writes", 38'(wr_q.size()), 38'd0);

    // Zero tap count: no bus write, sticky error
    pulse_cfg(16'd0);
    repeat (5) @(negedge clk);
    chk("zero taps writes", 38'(wr_q.size()), 38'd0);
    chk("zero taps err_sticky", 38'(err_sticky), 38'd1);
    chk("zero taps idle", 38'(busy), 38'd0);

    chk("wr/rd overlap", 38'(both_cnt), 38'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
